// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 timing constants for the VGA character path.
// Holds the default porch/sync/active widths, derived totals, the
// coordinate width used for x/y, the default sync polarity, the decoded
// timing record and a counter-width helper. The renderer imports the same
// constants for its active-area bounds.
package vga_pkg;

  localparam int unsigned H_SYNC_640   = 96;
  localparam int unsigned H_BP_640     = 48;
  localparam int unsigned H_ACTIVE_640 = 640;
  localparam int unsigned H_FP_640     = 16;
  localparam int unsigned V_SYNC_640   = 2;
  localparam int unsigned V_BP_640     = 33;
  localparam int unsigned V_ACTIVE_640 = 480;
  localparam int unsigned V_FP_640     = 10;

  localparam int unsigned H_TOTAL_640 = H_SYNC_640 + H_BP_640 + H_ACTIVE_640 + H_FP_640;
  localparam int unsigned V_TOTAL_640 = V_SYNC_640 + V_BP_640 + V_ACTIVE_640 + V_FP_640;
  localparam int unsigned H_START_640 = H_SYNC_640 + H_BP_640;
  localparam int unsigned V_START_640 = V_SYNC_640 + V_BP_640;

  localparam int unsigned COORD_W      = 10;
  localparam logic        SYNC_ACT_DEF = 1'b0;

  typedef logic [COORD_W-1:0] coord_t;

  // Everything the timing stage presents to the renderer for one pixel.
  typedef struct packed {
    logic   hsync;
    logic   vsync;
    logic   de;
    coord_t x;
    coord_t y;
    logic   line_start;
    logic   frame_start;
  } vga_timing_t;

  // Bits needed to count 0..total-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned total);
    return (total <= 2) ? 1 : $clog2(total);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// mod_counter: modulo-MOD up counter with clock enable and synchronous clear.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (priority over ce)
//   ce       : advance one step
//   count    : current value 0..MOD-1
//   wrap     : high when this ce step rolls MOD-1 -> 0 (use as next stage ce)
module mod_counter #(
  parameter int unsigned MOD = 800,
  parameter int unsigned W   = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ce,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = ce && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (ce) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing from the 50 MHz board clock.
// Generates a 25 MHz pixel strobe, horizontal/vertical position counters and
// registered sync / data-enable / active-area coordinates / line and frame
// markers, plus a count of completed frames.
//   clk, rst     : board clock, asynchronous active-high reset
//   enable       : run timing; low parks everything blanked at the origin
//   pix_ce       : pixel strobe, high every second clk
//   hsync, vsync : syncs, SYNC_ACT while in the sync interval
//   de           : active-video enable
//   x, y         : active-area column/row, 0 outside the active area
//   line_start   : one-clk pulse for pixel h=0
//   frame_start  : one-clk pulse for pixel h=0, v=0
//   frame_cnt    : frames completed, modulo 256 (kept across enable low)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = H_SYNC_640,
  parameter int unsigned H_BP     = H_BP_640,
  parameter int unsigned H_ACTIVE = H_ACTIVE_640,
  parameter int unsigned H_FP     = H_FP_640,
  parameter int unsigned V_SYNC   = V_SYNC_640,
  parameter int unsigned V_BP     = V_BP_640,
  parameter int unsigned V_ACTIVE = V_ACTIVE_640,
  parameter int unsigned V_FP     = V_FP_640,
  parameter logic        SYNC_ACT = SYNC_ACT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  output logic               pix_ce,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned CNT_W   = cnt_width((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL);

  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] V_DE_BEG   = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] V_DE_END   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);

  localparam vga_timing_t IDLE = '{
    hsync:       ~SYNC_ACT,
    vsync:       ~SYNC_ACT,
    de:          1'b0,
    x:           '0,
    y:           '0,
    line_start:  1'b0,
    frame_start: 1'b0
  };

  logic             run_q;
  logic             step;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             h_wrap;
  logic             v_wrap;
  logic [7:0]       frame_acc;
  logic             h_de;
  logic             v_de;
  vga_timing_t      nxt;
  vga_timing_t      tim;

  // run_q delays enable by one clk so the output register blanks on the clk
  // after the counters are parked, and unblanks together with the first
  // decoded pixel after re-enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_ce <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      pix_ce <= enable & ~pix_ce;
      run_q  <= enable;
    end
  end

  assign step = pix_ce & enable;

  mod_counter #(.MOD(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (~enable),
    .ce    (step),
    .count (h_cnt),
    .wrap  (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (~enable),
    .ce    (h_wrap),
    .count (v_cnt),
    .wrap  (v_wrap)
  );

  // Internal frame count steps on the raster wrap; the visible frame_cnt
  // picks it up one pixel later so it changes together with frame_start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_acc <= '0;
    end else if (v_wrap) begin
      frame_acc <= frame_acc + 8'd1;
    end
  end

  always_comb begin
    h_de            = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
    v_de            = (v_cnt >= V_DE_BEG) && (v_cnt < V_DE_END);
    nxt             = IDLE;
    nxt.hsync       = (h_cnt < H_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
    nxt.vsync       = (v_cnt < V_SYNC_END) ? SYNC_ACT : ~SYNC_ACT;
    nxt.de          = h_de && v_de;
    nxt.x           = nxt.de ? COORD_W'(h_cnt - H_DE_BEG) : '0;
    nxt.y           = nxt.de ? COORD_W'(v_cnt - V_DE_BEG) : '0;
    nxt.line_start  = (h_cnt == '0);
    nxt.frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tim       <= IDLE;
      frame_cnt <= '0;
    end else if (!run_q) begin
      tim <= IDLE;
    end else if (pix_ce) begin
      tim       <= nxt;
      frame_cnt <= frame_acc;
    end else begin
      // Markers last one clk; the pixel fields hold for the second clk.
      tim.line_start  <= 1'b0;
      tim.frame_start <= 1'b0;
    end
  end

  assign hsync       = tim.hsync;
  assign vsync       = tim.vsync;
  assign de          = tim.de;
  assign x           = tim.x;
  assign y           = tim.y;
  assign line_start  = tim.line_start;
  assign frame_start = tim.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed bench for vga_timing_gen.
// u_a runs the full 640x480 timing (reset, strobe, line and vsync timing).
// u_b uses a tiny raster (9x6 total, 4x3 active, active-high syncs) so whole
// frames, the 256-frame wrap and enable drop/restart fit in a short run.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst;
  logic en_a;
  logic en_b;

  logic       a_pix_ce, a_hsync, a_vsync, a_de, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic [7:0] a_fc;
  logic       b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] b_fc;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .enable(en_a),
    .pix_ce(a_pix_ce), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
  );

  vga_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .SYNC_ACT(1'b1)
  ) u_b (
    .clk(clk), .rst(rst), .enable(en_b),
    .pix_ce(b_pix_ce), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs u_b for ncyc clks right after enable rises, comparing every sample
  // against a raster model indexed by clk count: sample k>=2 shows pixel
  // p=(k-2)/2 of a 9x6 raster (54 pixels per frame).
  task automatic run_b(input int ncyc, input int fc_base,
                       output int errs, output int n_fs, output int n_de0,
                       output int first_de_k, output int last_x, output int last_y);
    int p, h, v;
    logic e_pce, e_hs, e_vs, e_de, e_ls, e_fs;
    int e_x, e_y, e_fc;
    errs = 0; n_fs = 0; n_de0 = 0; first_de_k = -1; last_x = -1; last_y = -1;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      p = (k >= 2) ? (k - 2) / 2 : 0;
      h = p % 9;
      v = (p / 9) % 6;
      if (k == 1) begin
        e_pce = 1'b1; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0;
        e_ls = 1'b0; e_fs = 1'b0; e_x = 0; e_y = 0; e_fc = fc_base;
      end else begin
        e_pce = (k % 2 == 1);
        e_hs  = (h < 2);
        e_vs  = (v < 1);
        e_de  = (h >= 4) && (h < 8) && (v >= 2) && (v < 5);
        e_x   = e_de ? h - 4 : 0;
        e_y   = e_de ? v - 2 : 0;
        e_ls  = (k % 2 == 0) && (h == 0);
        e_fs  = e_ls && (v == 0);
        e_fc  = (fc_base + p / 54) % 256;
      end
      if ({b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs} !== {e_pce, e_hs, e_vs, e_de, e_ls, e_fs})
        errs++;
      if (b_x !== 10'(e_x) || b_y !== 10'(e_y) || b_fc !== 8'(e_fc))
        errs++;
      if (b_fs === 1'b1) n_fs++;
      if (b_de === 1'b1 && first_de_k < 0) first_de_k = k;
      if (k >= 2 && p < 54 && b_de === 1'b1 && b_pix_ce === 1'b0) begin
        n_de0++;
        last_x = int'(b_x);
        last_y = int'(b_y);
      end
      if (k >= 2 && p == 256 * 54 - 1 && k % 2 == 1)
        chk("B frame_cnt before wrap", b_fc, 255);
      if (k >= 2 && p == 256 * 54 && k % 2 == 0) begin
        chk("B frame_cnt wrap", b_fc, 0);
        chk("B frame_start at wrap", b_fs, 1);
      end
    end
  endtask

  initial begin
    int hs_prev, ls_prev, hs_fall1, hs_fall2, hs_low, vs_low;
    int n_ls, ls_k1, ls_k2, ls_dbl, de_cnt, fs_cnt;
    int errs, n_fs, n_de0, first_de_k, last_x, last_y;

    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    repeat (5) tick();
    chk("A reset flags", {a_pix_ce, a_hsync, a_vsync, a_de, a_ls, a_fs}, 6'b011000);
    chk("A reset x", a_x, 0);
    chk("A reset y", a_y, 0);
    chk("A reset frame_cnt", a_fc, 0);
    chk("B reset flags", {b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs}, 6'b000000);

    // Full-size line timing on u_a.
    rst = 1'b0; en_a = 1'b1;
    hs_prev = 1; ls_prev = 0; hs_fall1 = 0; hs_fall2 = 0; hs_low = 0; vs_low = 0;
    n_ls = 0; ls_k1 = 0; ls_k2 = 0; ls_dbl = 0; de_cnt = 0; fs_cnt = 0;
    for (int k = 1; k <= 3300; k++) begin
      tick();
      if (k <= 4) chk($sformatf("A pix_ce k%0d", k), a_pix_ce, k % 2);
      if (k == 2) chk("A first pixel hsync/ls/fs", {a_hsync, a_ls, a_fs}, 3'b011);
      if (hs_prev == 1 && a_hsync === 1'b0) begin
        if (hs_fall1 == 0) hs_fall1 = k;
        else if (hs_fall2 == 0) hs_fall2 = k;
      end
      if (a_hsync === 1'b0 && k < 1602) hs_low++;
      if (a_vsync === 1'b0) vs_low++;
      if (a_ls === 1'b1) begin
        n_ls++;
        if (n_ls == 1) ls_k1 = k;
        if (n_ls == 2) ls_k2 = k;
        if (ls_prev == 1) ls_dbl++;
      end
      if (a_de === 1'b1) de_cnt++;
      if (a_fs === 1'b1) fs_cnt++;
      hs_prev = (a_hsync === 1'b1) ? 1 : 0;
      ls_prev = (a_ls === 1'b1) ? 1 : 0;
    end
    chk("A hsync period", hs_fall2 - hs_fall1, 1600);
    chk("A hsync active", hs_low, 192);
    chk("A line_start count", n_ls, 3);
    chk("A line_start period", ls_k2 - ls_k1, 1600);
    chk("A line_start double", ls_dbl, 0);
    chk("A vsync active", vs_low, 3200);
    chk("A frame_start count", fs_cnt, 1);
    chk("A de in top lines", de_cnt, 0);

    // Small raster: 257 frames plus a partial one.
    en_b = 1'b1;
    run_b(27816, 0, errs, n_fs, n_de0, first_de_k, last_x, last_y);
    chk("B model run1", errs, 0);
    chk("B frame_start count run1", n_fs, 258);
    chk("B de per frame", n_de0, 12);
    chk("B first de clk", first_de_k, 46);
    chk("B last de x", last_x, 3);
    chk("B last de y", last_y, 2);

    // Drop enable mid-frame (pixel h=2, v=3).
    en_b = 1'b0;
    tick();
    chk("B pix_ce after drop", b_pix_ce, 0);
    tick();
    chk("B blanked flags", {b_hsync, b_vsync, b_de, b_ls, b_fs}, 5'b00000);
    chk("B blanked xy", {b_x, b_y}, 0);
    repeat (5) tick();
    chk("B idle flags", {b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs}, 6'b000000);
    chk("B frame_cnt retained", b_fc, 1);

    en_b = 1'b1;
    run_b(220, 1, errs, n_fs, n_de0, first_de_k, last_x, last_y);
    chk("B model run2", errs, 0);
    chk("B frame_start count run2", n_fs, 3);
    chk("B de per frame run2", n_de0, 12);
    chk("B first de clk run2", first_de_k, 46);

    // Asynchronous reset between clock edges.
    chk("B hsync before rst", b_hsync, 1);
    chk("B frame_cnt before rst", b_fc, 3);
    #5 rst = 1'b1;
    #2;
    chk("B async rst flags", {b_pix_ce, b_hsync, b_vsync, b_de, b_ls, b_fs}, 6'b000000);
    chk("B async rst frame_cnt", b_fc, 0);
    chk("A async rst flags", {a_pix_ce, a_hsync, a_vsync, a_de, a_ls, a_fs}, 6'b011000);
    chk("A async rst frame_cnt", a_fc, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
